// File: rtl/alu_accum.sv
// Accumulator ALU: single-cycle ops on {A, Q[WIDTH-1:0]} plus a WIDTH-cycle shift-add multiply.
// Q, carry and done are registered; busy reflects the MUL state.
module alu_accum #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         func,
  input  logic [WIDTH-1:0]   a_in,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               busy,
  output logic               done
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   q;
  logic            c;
  logic            done_r;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]   mcand;
  logic [AW-1:0]   prod;
  logic [CW-1:0]   cnt;
  logic            mul_last;
  logic [AW-1:0]   prod_nxt;
  logic [AW:0]     op_res;

  // Returns {carry, value}; only the accumulate op can set the top bit.
  function automatic logic [AW:0] alu_op(input logic [2:0] f, input logic [WIDTH-1:0] a,
                                         input logic [AW-1:0] qv);
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
    logic [AW:0]      r;
    b = qv[WIDTH-1:0];
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    case (f)
      3'b000: r = {1'b0, a, b};
      3'b001: r = {{WIDTH{1'b0}}, s};
      3'b010: r = {1'b0, qv} + {{(WIDTH+1){1'b0}}, a};
      3'b011: r = {1'b0, a | b, a ^ b};
      3'b100: r = {{AW{1'b0}}, |{a, b}};
      3'b101: r = (32'(a) >= AW) ? '0 : {1'b0, {{WIDTH{1'b0}}, b} << a};
      3'b110: r = (32'(a) >= WIDTH) ? '0 : {{(WIDTH+1){1'b0}}, b >> a};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op_res   = alu_op(func, a_in, q);
  assign mul_last = (cnt == LAST);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && func == 3'b111) state_nxt = MUL;
      MUL:  if (mul_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      c      <= 1'b0;
      done_r <= 1'b0;
      mplier <= '0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      done_r <= 1'b0;
      if (clear) begin
        q      <= '0;
        c      <= 1'b0;
        mplier <= '0;
        mcand  <= '0;
        prod   <= '0;
        cnt    <= '0;
      end else if (state == IDLE) begin
        if (start && func == 3'b111) begin
          mcand  <= {{WIDTH{1'b0}}, a_in};
          mplier <= q[WIDTH-1:0];
          prod   <= '0;
          cnt    <= '0;
        end else if (start) begin
          q      <= op_res[AW-1:0];
          c      <= op_res[AW];
          done_r <= 1'b1;
        end
      end else begin
        // One partial product per cycle; the last one lands straight in Q.
        prod   <= prod_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          q      <= prod_nxt;
          c      <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign result = q;
  assign carry  = c;
  assign busy   = (state == MUL);
  assign done   = done_r;

endmodule

// File: tb/tb_alu_accum.sv
// Directed bench for alu_accum (WIDTH=4); inputs change and outputs are sampled on the falling edge.
module tb_alu_accum;

  logic       clk = 1'b0;
  logic       reset, clear, start;
  logic [2:0] func;
  logic [3:0] a_in;
  logic [7:0] result;
  logic       carry, busy, done;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  alu_accum #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .func(func),
    .a_in(a_in), .result(result), .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op at a falling edge; returns at the falling edge after the executing rising edge.
  task automatic op(input logic [2:0] f, input logic [3:0] a);
    start = 1'b1; func = f; a_in = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  always @(negedge clk)
    if (mon_en) check("busy_done_excl", {31'd0, busy & done}, 32'd0);

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit seen_done;
    reset = 1'b1; clear = 1'b0; start = 1'b0; func = 3'b000; a_in = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Make the state nonzero, then reset between edges.
    op(3'b000, 4'h5);
    check("preload", result, 32'h50);
    #2 reset = 1'b1;
    #1;
    check("rst_result", result, 32'h00);
    check("rst_carry", carry, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Add chain
    op(3'b001, 4'h5);
    check("add1_result", result, 32'h05);
    check("add1_done", done, 32'd1);
    @(negedge clk);
    check("add1_done_low", done, 32'd0);
    op(3'b001, 4'hF);
    check("add2_result", result, 32'h14);
    check("add2_carry", carry, 32'd0);

    // Multiply 3 * 4, with a start pulse and operand changes while busy
    op(3'b111, 4'h3);
    cyc = 0;
    while (busy && cyc < 10) begin
      check("mul_hold", result, 32'h14);
      check("mul_done_low", done, 32'd0);
      start = (cyc == 1); func = 3'b001; a_in = 4'h9;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("mul_busy_cycles", cyc, 32'd4);
    check("mul_result", result, 32'h0C);
    check("mul_done", done, 32'd1);
    check("mul_carry", carry, 32'd0);
    @(negedge clk);
    check("mul_done_once", done, 32'd0);
    check("mul_no_queue", result, 32'h0C);
    check("mul_idle", busy, 32'd0);

    // Accumulate overflow
    do_clear();
    check("clr_result", result, 32'h00);
    op(3'b001, 4'hE);
    check("acc_load", result, 32'h0E);
    op(3'b000, 4'hF);
    check("acc_concat", result, 32'hFE);
    op(3'b010, 4'h3);
    check("acc_wrap", result, 32'h01);
    check("acc_carry", carry, 32'd1);
    op(3'b011, 4'h2);
    check("orxor_result", result, 32'h33);
    check("orxor_carry", carry, 32'd0);

    // Shifts and reduction-OR
    do_clear();
    op(3'b001, 4'h1);
    op(3'b101, 4'h7);
    check("shl7", result, 32'h80);
    do_clear();
    op(3'b001, 4'h1);
    op(3'b101, 4'h8);
    check("shl8_zero", result, 32'h00);
    op(3'b001, 4'h8);
    op(3'b110, 4'h3);
    check("shr3", result, 32'h01);
    op(3'b110, 4'h4);
    check("shr4_zero", result, 32'h00);
    op(3'b100, 4'h0);
    check("redor_zero", result, 32'h00);
    op(3'b100, 4'h4);
    check("redor_one", result, 32'h01);

    // Clear at the 2nd MUL cycle
    op(3'b001, 4'h5);
    op(3'b111, 4'h5);
    @(negedge clk);
    check("abort_clr_busy_before", busy, 32'd1);
    do_clear();
    check("abort_clr_result", result, 32'h00);
    check("abort_clr_busy", busy, 32'd0);
    seen_done = done;
    repeat (6) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("abort_clr_no_done", seen_done, 32'd0);
    check("abort_clr_no_write", result, 32'h00);

    // Reset mid-multiply
    op(3'b001, 4'h5);
    op(3'b111, 4'h5);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_rst_result", result, 32'h00);
    check("abort_rst_busy", busy, 32'd0);
    seen_done = done;
    repeat (6) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("abort_rst_no_done", seen_done, 32'd0);
    op(3'b001, 4'h6);
    check("after_rst_op", result, 32'h06);

    // start together with clear is dropped
    op(3'b001, 4'h1);
    start = 1'b1; func = 3'b001; a_in = 4'h5; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("start_clr_result", result, 32'h00);
    check("start_clr_done", done, 32'd0);
    start = 1'b1; func = 3'b111; a_in = 4'h3; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("start_clr_mul_busy", busy, 32'd0);

    // Back-to-back single-cycle ops
    start = 1'b1; func = 3'b001; a_in = 4'h2;
    @(negedge clk);
    check("b2b_first", result, 32'h02);
    a_in = 4'h3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second", result, 32'h05);
    check("b2b_done", done, 32'd1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
